// File: rtl/alu_arb_pkg.sv
// Shared definitions for the round-robin ALU arbiter: op codes, FSM states
// and the width of the optional statistics counters.
package alu_arb_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_MAX  = 3'd4;

  localparam int unsigned STAT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_2_13.sv
// Shared combinational ALU core. Add/sub wrap at WIDTH bits, mul gives the
// full 2*WIDTH product, logic ops are bitwise; narrow results are zero-extended.
module alu_2_13
  import alu_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [2:0]         i_op,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_y
);

  logic [WIDTH-1:0]   w_narrow;
  logic [2*WIDTH-1:0] w_a_ext;
  logic [2*WIDTH-1:0] w_b_ext;

  assign w_a_ext = {{WIDTH{1'b0}}, i_a};
  assign w_b_ext = {{WIDTH{1'b0}}, i_b};

  // Select the result for the current op code
  always_comb begin
    w_narrow = '0;
    o_y      = '0;
    case (i_op)
      OP_ADD: begin
        w_narrow = i_a + i_b;
        o_y      = {{WIDTH{1'b0}}, w_narrow};
      end
      OP_SUB: begin
        w_narrow = i_a - i_b;
        o_y      = {{WIDTH{1'b0}}, w_narrow};
      end
      OP_MUL: o_y = w_a_ext * w_b_ext;
      OP_NOR: begin
        w_narrow = ~(i_a | i_b);
        o_y      = {{WIDTH{1'b0}}, w_narrow};
      end
      OP_NAND: begin
        w_narrow = ~(i_a & i_b);
        o_y      = {{WIDTH{1'b0}}, w_narrow};
      end
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one ALU core between two requesters.
// IDLE grants and captures a request, EXEC registers the ALU result,
// RESP holds the tagged response until the consumer takes it.
// Optional statistics counters are enabled by defining ALU_RR_ARBITER_STATS_EN.
module alu_rr_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2:0]         req_op0,
  input  logic [2:0]         req_op1,
  input  logic [WIDTH-1:0]   req_a0,
  input  logic [WIDTH-1:0]   req_b0,
  input  logic [WIDTH-1:0]   req_a1,
  input  logic [WIDTH-1:0]   req_b1,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [2*WIDTH-1:0] rsp_data,
  output logic               rsp_err,
  output logic               busy
`ifdef ALU_RR_ARBITER_STATS_EN
  ,
  output logic [STAT_W-1:0]  grant_cnt0,
  output logic [STAT_W-1:0]  grant_cnt1,
  output logic [STAT_W-1:0]  err_cnt
`endif
);

  state_e             r_state;
  state_e             w_state_next;
  logic [2:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_id;
  logic               r_last_grant;
  logic [2*WIDTH-1:0] r_rsp_data;
  logic               r_rsp_err;

  logic [1:0]         w_grant;
  logic               w_accept;
  logic               w_sel_id;
  logic               w_op_illegal;
  logic [2:0]         w_alu_op;
  logic [2*WIDTH-1:0] w_alu_y;
  logic               w_rsp_take;

  // Grant at most one requester in IDLE; on contention prefer the one not served last
  always_comb begin
    w_grant = 2'b00;
    if (r_state == ST_IDLE) begin
      unique case (req_valid)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        2'b11:   w_grant = r_last_grant ? 2'b01 : 2'b10;
        default: w_grant = 2'b00;
      endcase
    end
  end

  // A grant is only ever issued to a valid requester, so any grant is a handshake
  assign w_accept   = |w_grant;
  assign w_sel_id   = w_grant[1];
  assign w_rsp_take = (r_state == ST_RESP) && rsp_ready;

  // Illegal op codes run the ALU as an add; the result is discarded anyway
  assign w_op_illegal = (r_op > OP_MAX);
  assign w_alu_op     = w_op_illegal ? OP_ADD : r_op;

  alu_2_13 #(
    .WIDTH (WIDTH)
  ) u_alu (
    .i_op (w_alu_op),
    .i_a  (r_a),
    .i_b  (r_b),
    .o_y  (w_alu_y)
  );

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept) w_state_next = ST_EXEC;
      ST_EXEC: w_state_next = ST_RESP;
      ST_RESP: if (rsp_ready) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Operand capture on accept and result registration in EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_id         <= 1'b0;
      r_last_grant <= 1'b1;
      r_rsp_data   <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op         <= w_sel_id ? req_op1 : req_op0;
        r_a          <= w_sel_id ? req_a1  : req_a0;
        r_b          <= w_sel_id ? req_b1  : req_b0;
        r_id         <= w_sel_id;
        r_last_grant <= w_sel_id;
      end
      if (r_state == ST_EXEC) begin
        r_rsp_data <= w_op_illegal ? '0 : w_alu_y;
        r_rsp_err  <= w_op_illegal;
      end
    end
  end

  assign req_ready = w_grant;
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_id    = r_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign busy      = (r_state != ST_IDLE);

`ifdef ALU_RR_ARBITER_STATS_EN
  logic [STAT_W-1:0] r_grant_cnt0;
  logic [STAT_W-1:0] r_grant_cnt1;
  logic [STAT_W-1:0] r_err_cnt;

  // Saturating per-requester grant counters and error-response counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant_cnt0 <= '0;
      r_grant_cnt1 <= '0;
      r_err_cnt    <= '0;
    end else begin
      if (w_accept && !w_sel_id && (r_grant_cnt0 != '1)) r_grant_cnt0 <= r_grant_cnt0 + 1'b1;
      if (w_accept && w_sel_id && (r_grant_cnt1 != '1))  r_grant_cnt1 <= r_grant_cnt1 + 1'b1;
      if (w_rsp_take && r_rsp_err && (r_err_cnt != '1))  r_err_cnt    <= r_err_cnt + 1'b1;
    end
  end

  assign grant_cnt0 = r_grant_cnt0;
  assign grant_cnt1 = r_grant_cnt1;
  assign err_cnt    = r_err_cnt;
`else
  logic w_unused_take;
  assign w_unused_take = w_rsp_take;
`endif

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed self-checking bench for alu_rr_arbiter (WIDTH=4).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_alu_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [2:0] req_op0;
  logic [2:0] req_op1;
  logic [3:0] req_a0;
  logic [3:0] req_b0;
  logic [3:0] req_a1;
  logic [3:0] req_b1;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       busy;
`ifdef ALU_RR_ARBITER_STATS_EN
  logic [15:0] grant_cnt0;
  logic [15:0] grant_cnt1;
  logic [15:0] err_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  alu_rr_arbiter #(
    .WIDTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op0   (req_op0),
    .req_op1   (req_op1),
    .req_a0    (req_a0),
    .req_b0    (req_b0),
    .req_a1    (req_a1),
    .req_b1    (req_b1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy)
`ifdef ALU_RR_ARBITER_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1),
    .err_cnt    (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete transaction with rsp_ready held high
  task automatic run_op(input string tag, input int id, input logic [2:0] op,
                        input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] exp_data, input logic exp_err);
    @(negedge clk);
    rsp_ready = 1'b1;
    if (id == 0) begin
      req_valid = 2'b01; req_op0 = op; req_a0 = a; req_b0 = b;
    end else begin
      req_valid = 2'b10; req_op1 = op; req_a1 = a; req_b1 = b;
    end
    #1;
    check({tag, ".ready"}, 16'(req_ready), (id == 0) ? 16'h1 : 16'h2);
    @(posedge clk);
    #1;
    // Operands may change after acceptance without affecting the result
    req_valid = 2'b00;
    req_a0 = ~a; req_b0 = ~b; req_a1 = ~a; req_b1 = ~b;
    @(negedge clk);
    #1;
    check({tag, ".exec_busy"}, 16'(busy), 16'h1);
    check({tag, ".exec_valid"}, 16'(rsp_valid), 16'h0);
    @(negedge clk);
    #1;
    check({tag, ".valid"}, 16'(rsp_valid), 16'h1);
    check({tag, ".data"}, 16'(rsp_data), 16'(exp_data));
    check({tag, ".id"}, 16'(rsp_id), 16'(id));
    check({tag, ".err"}, 16'(rsp_err), 16'(exp_err));
    @(negedge clk);
    #1;
    check({tag, ".idle_busy"}, 16'(busy), 16'h0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 2'b00; rsp_ready = 1'b0;
    req_op0 = 3'd0; req_op1 = 3'd0;
    req_a0 = 4'd0; req_b0 = 4'd0; req_a1 = 4'd0; req_b1 = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset.valid", 16'(rsp_valid), 16'h0);
    check("reset.busy", 16'(busy), 16'h0);
    check("reset.ready", 16'(req_ready), 16'h0);
    check("reset.data", 16'(rsp_data), 16'h0);
    check("reset.id", 16'(rsp_id), 16'h0);
    check("reset.err", 16'(rsp_err), 16'h0);
`ifdef ALU_RR_ARBITER_STATS_EN
    check("reset.gcnt0", grant_cnt0, 16'h0);
    check("reset.gcnt1", grant_cnt1, 16'h0);
    check("reset.ecnt", err_cnt, 16'h0);
`endif

    // Basic ops: add wrap, sub wrap, full mul, nor, nand
    run_op("add_wrap", 0, 3'd0, 4'd9,  4'd8,  8'h01, 1'b0);
    run_op("sub_wrap", 1, 3'd1, 4'd3,  4'd5,  8'h0E, 1'b0);
    run_op("mul_full", 1, 3'd2, 4'd15, 4'd15, 8'hE1, 1'b0);
    run_op("nor",      0, 3'd3, 4'hA,  4'h5,  8'h00, 1'b0);
    run_op("nand",     1, 3'd4, 4'hF,  4'h7,  8'h08, 1'b0);

    // Fairness: both requesters always valid, last grant was requester 1
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    req_op0 = 3'd0; req_a0 = 4'd1; req_b0 = 4'd2;
    req_op1 = 3'd2; req_a1 = 4'd3; req_b1 = 4'd3;
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("fair%0d.ready", k), 16'(req_ready), (k % 2 == 0) ? 16'h1 : 16'h2);
      @(negedge clk);
      @(negedge clk);
      #1;
      check($sformatf("fair%0d.valid", k), 16'(rsp_valid), 16'h1);
      check($sformatf("fair%0d.id", k), 16'(rsp_id), 16'(k % 2));
      check($sformatf("fair%0d.data", k), 16'(rsp_data), (k % 2 == 0) ? 16'h03 : 16'h09);
      @(negedge clk);
    end
    req_valid = 2'b00;

    // Backpressure: response held for several cycles while both requesters wait
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 2'b01; req_op0 = 3'd0; req_a0 = 4'd2; req_b0 = 4'd3;
    #1;
    check("bp.ready", 16'(req_ready), 16'h1);
    @(posedge clk);
    #1;
    req_valid = 2'b11; req_a0 = 4'd7; req_op1 = 3'd0;
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("bp%0d.valid", k), 16'(rsp_valid), 16'h1);
      check($sformatf("bp%0d.data", k), 16'(rsp_data), 16'h05);
      check($sformatf("bp%0d.id", k), 16'(rsp_id), 16'h0);
      check($sformatf("bp%0d.ready", k), 16'(req_ready), 16'h0);
      check($sformatf("bp%0d.busy", k), 16'(busy), 16'h1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp.release_valid", 16'(rsp_valid), 16'h0);
    check("bp.release_ready", 16'(req_ready), 16'h2);
    req_valid = 2'b00;

    // Illegal op code
    run_op("illegal", 1, 3'd6, 4'd5, 4'd5, 8'h00, 1'b1);

    // Reset during EXEC drops the op
    @(negedge clk);
    req_valid = 2'b10; req_op1 = 3'd0; req_a1 = 4'd1; req_b1 = 4'd1;
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    @(negedge clk);
    #1;
    check("rst_mid.exec_busy", 16'(busy), 16'h1);
`ifdef ALU_RR_ARBITER_STATS_EN
    check("stats.gcnt0", grant_cnt0, 16'd6);
    check("stats.gcnt1", grant_cnt1, 16'd8);
    check("stats.ecnt", err_cnt, 16'd1);
`endif
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("rst_mid.valid", 16'(rsp_valid), 16'h0);
    check("rst_mid.busy", 16'(busy), 16'h0);
    check("rst_mid.data", 16'(rsp_data), 16'h0);
`ifdef ALU_RR_ARBITER_STATS_EN
    check("rst_mid.gcnt0", grant_cnt0, 16'h0);
    check("rst_mid.gcnt1", grant_cnt1, 16'h0);
    check("rst_mid.ecnt", err_cnt, 16'h0);
`endif
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("rst_mid.no_rsp%0d", k), 16'(rsp_valid), 16'h0);
    end
    req_valid = 2'b11;
    #1;
    check("rst_mid.first_grant", 16'(req_ready), 16'h1);
    @(negedge clk);
    req_valid = 2'b00;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares one combinational ALU datapath between two requesters.
- Round-robin arbitration; per-requester valid/ready request channel; single valid/ready response channel tagged with requester ID.
- Operands are registered on accept; result is registered before presentation.
- Sits between the two client blocks and the shared ALU core. It is the only driver of the ALU's control and operand inputs.

Parameters:
- WIDTH, 4, operand width; result width is 2*WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  2  bit i: requester i presents an op.
- req_ready  output  2  bit i: arbiter accepts requester i this cycle.
- req_op0, req_op1  input  3 each  op code (0 add, 1 sub, 2 mul, 3 nor, 4 nand).
- req_a0, req_b0, req_a1, req_b1  input  WIDTH each  operands.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer takes result.
- rsp_id  output  1  requester that issued the op.
- rsp_data  output  2*WIDTH  result.
- rsp_err  output  1  op code was illegal (5..7).
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset values: state=IDLE, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, busy=0, req_ready=0, last_grant=1 (so requester 0 wins first).
- FSM states are IDLE, EXEC and RESP.
- IDLE:
  - req_ready is combinational and has at most one bit set.
  - If only one req_valid bit is set, that requester gets ready.
  - If both are set, the requester != last_grant gets ready.
  - On handshake (req_valid[i] & req_ready[i]): capture op/a/b and id=i; last_grant<=i; go to EXEC.
  - With no valid request, stay in IDLE.
- EXEC (exactly 1 cycle):
  - Drive the ALU from the captured registers.
  - Register the result into rsp_data.
  - If op>4: rsp_data<=0 and rsp_err<=1; otherwise rsp_err<=0.
  - Go to RESP.
- RESP:
  - rsp_valid=1.
  - rsp_data, rsp_id and rsp_err are held stable until rsp_ready.
  - On rsp_valid & rsp_ready: rsp_valid<=0 and go to IDLE.
  - req_ready=0 while in this state.
- Latency: accept cycle N gives rsp_valid high at N+2. Best-case throughput is one op per 3 cycles.
- No new request is accepted in the cycle the response is taken; acceptance resumes the following cycle.
- Arithmetic:
  - add and sub: WIDTH-bit result, wraps modulo 2^WIDTH, zero-extended to 2*WIDTH.
  - mul: full 2*WIDTH unsigned product.
  - nor and nand: bitwise over WIDTH bits, zero-extended.
- Requester inputs are sampled only on the handshake cycle. A requester may change operands after acceptance.
- A request deasserted before acceptance is never executed.
- rst asserted in any state returns all registers to reset values on the next edge. An in-flight op is dropped and no response is produced; last_grant returns to 1.
- busy = (state != IDLE).

Optional Feature:
- Macro: ALU_RR_ARBITER_STATS_EN.
- Defined:
  - Adds outputs grant_cnt0 and grant_cnt1 (16 bits each), counting accepted requests per requester.
  - Adds output err_cnt (16 bits), counting responses with rsp_err=1.
  - All three counters saturate at 16'hFFFF and are cleared by rst.
- Undefined: these ports and counters do not exist; core behaviour is identical.

Decomposition:
- Package alu_arb_pkg holds:
  - op code constants OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_NOR=3, OP_NAND=4, and OP_MAX=4;
  - state encoding ST_IDLE, ST_EXEC, ST_RESP;
  - the stats counter width STAT_W=16.
- One sub-module: the existing ALU core alu_2_13 (WIDTH passed through), instantiated once. Control is driven with the captured op when op<=4 and forced to 0 otherwise.
- Arbitration and FSM stay in the top level.

Test Plan (WIDTH=4):
1. Add wrap: after reset, req_valid=2'b01, op0=0, a=9, b=8 → req_ready=2'b01 in cycle N; at N+2 rsp_valid=1, rsp_data=8'h01, rsp_id=0, rsp_err=0.
2. Sub and mul: requester 1 sends op1=1, a=3, b=5 → rsp_data=8'h0E, rsp_id=1. Requester 1 then sends op1=2, a=15, b=15 → rsp_data=8'hE1.
3. Logic ops: op=3 with a=4'b1010, b=4'b0101 → 8'h00; op=4 with a=4'hF, b=4'h7 → 8'h08.
4. Fairness: both req_valid held high for 6 ops, rsp_ready=1 → accepted IDs 0,1,0,1,0,1; each rsp_id matches its request.
5. Backpressure and illegal op:
   - rsp_ready=0 for 5 cycles in RESP → rsp_data and rsp_id stable, req_ready=2'b00, busy=1.
   - op=6 → rsp_err=1, rsp_data=0.
6. Reset mid-op: rst pulsed during EXEC → next cycle rsp_valid=0, busy=0, no response ever appears. With both requesters valid afterwards, requester 0 is granted first. With ALU_RR_ARBITER_STATS_EN defined, all counters read 0 after the reset.
